// File: rtl/ag32gbd_frame_scanner_if.sv
`default_nettype none
// ============================================================================
// ag32gbd_frame_scanner_if : sampler handshake and frame-buffer write bus
// Rev 1.0
// ============================================================================
interface ag32gbd_frame_scanner_if;
    logic        SampleStart;
    logic [6:0]  PixelX;
    logic [6:0]  PixelY;
    logic        SampleDone;
    logic [1:0]  SampledValue;
    logic        FbWriteEn;
    logic [11:0] FbWriteAddr;
    logic [7:0]  FbWriteData;

    modport master (
        output SampleStart, PixelX, PixelY, FbWriteEn, FbWriteAddr, FbWriteData,
        input  SampleDone, SampledValue
    );

    modport slave (
        input  SampleStart, PixelX, PixelY, FbWriteEn, FbWriteAddr, FbWriteData,
        output SampleDone, SampledValue
    );
endinterface
`default_nettype wire

// File: rtl/ag32gbd_frame_scanner.sv
`default_nettype none
// ============================================================================
// ag32gbd_frame_scanner : walks the sensor raster, requests one sample per
// pixel and packs the 2-bit results into 2bpp tile bytes.      Rev 1.0
// ============================================================================
module ag32gbd_frame_scanner #(
    parameter int unsigned WIDTH      = 128,
    parameter int unsigned HEIGHT     = 112,
    parameter int unsigned START_HOLD = 4,
    parameter logic [15:0] TIMEOUT    = 16'd4095
) (
    input  wire                     sys_clock,
    input  wire                     sys_resetn,
    input  wire                     FrameStart,
    output logic                    FrameBusy,
    output logic                    FrameDone,
    output logic                    SampleError,
    ag32gbd_frame_scanner_if.master bus
);

    localparam logic [6:0]  c_XLAST     = 7'(WIDTH - 1);
    localparam logic [6:0]  c_YLAST     = 7'(HEIGHT - 1);
    localparam logic [7:0]  c_TPR       = 8'(WIDTH / 8);
    localparam logic [15:0] c_HOLD_LAST = 16'(START_HOLD - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_START     = 4'd1,
        S_WAIT_DONE = 4'd2,
        S_CAPTURE   = 4'd3,
        S_WRITE_LO  = 4'd4,
        S_WRITE_HI  = 4'd5,
        S_WAIT_LOW  = 4'd6,
        S_ADVANCE   = 4'd7,
        S_FINISH    = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [6:0]  r_x;
    logic [6:0]  r_y;
    logic [7:0]  r_plane0;
    logic [7:0]  r_plane1;
    logic [1:0]  r_v;
    logic [15:0] r_hold;
    logic [15:0] r_tmo;
    logic        r_done_q;
    logic        r_err;

    logic        w_edge;
    logic        w_timeout;
    logic        w_last_x;
    logic        w_last_y;
    logic [7:0]  w_tile;
    logic        w_start;
    logic        w_wen;
    logic [11:0] w_waddr;
    logic [7:0]  w_wdata;

    assign w_edge    = bus.SampleDone & ~r_done_q;
    assign w_timeout = (r_tmo >= TIMEOUT);
    assign w_last_x  = (r_x == c_XLAST);
    assign w_last_y  = (r_y == c_YLAST);
    // Tile index times 16 plus row-in-tile times 2 is just a concatenation.
    assign w_tile    = {4'b0000, r_y[6:3]} * c_TPR + {4'b0000, r_x[6:3]};

    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        FrameBusy   = 1'b0;
        FrameDone   = 1'b0;
        w_start     = 1'b0;
        w_wen       = 1'b0;
        w_waddr     = 12'd0;
        w_wdata     = 8'd0;
        case (r_state)
            S_IDLE: begin
                if (FrameStart) w_next = S_START;
            end
            S_START: begin
                FrameBusy = 1'b1;
                w_start   = 1'b1;
                if (r_hold == c_HOLD_LAST) w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                FrameBusy = 1'b1;
                if (w_edge || w_timeout) w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                FrameBusy = 1'b1;
                w_next    = (r_x[2:0] == 3'd7) ? S_WRITE_LO : S_WAIT_LOW;
            end
            S_WRITE_LO: begin
                FrameBusy = 1'b1;
                w_wen     = 1'b1;
                w_waddr   = {w_tile, r_y[2:0], 1'b0};
                w_wdata   = r_plane0;
                w_next    = S_WRITE_HI;
            end
            S_WRITE_HI: begin
                FrameBusy = 1'b1;
                w_wen     = 1'b1;
                w_waddr   = {w_tile, r_y[2:0], 1'b1};
                w_wdata   = r_plane1;
                w_next    = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                FrameBusy = 1'b1;
                if (!bus.SampleDone) w_next = S_ADVANCE;
            end
            S_ADVANCE: begin
                FrameBusy = 1'b1;
                w_next    = (w_last_x && w_last_y) ? S_FINISH : S_START;
            end
            S_FINISH: begin
                FrameDone = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_x      <= 7'd0;
            r_y      <= 7'd0;
            r_plane0 <= 8'd0;
            r_plane1 <= 8'd0;
            r_v      <= 2'd0;
            r_hold   <= 16'd0;
            r_tmo    <= 16'd0;
            r_done_q <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done_q <= bus.SampleDone;
            r_hold   <= (r_state == S_START) ? r_hold + 16'd1 : 16'd0;
            // Timeout window spans the whole request, hold phase included.
            r_tmo    <= (r_state == S_START || r_state == S_WAIT_DONE) ? r_tmo + 16'd1 : 16'd0;
            case (r_state)
                S_IDLE: begin
                    if (FrameStart) begin
                        r_x   <= 7'd0;
                        r_y   <= 7'd0;
                        r_err <= 1'b0;
                    end
                end
                S_WAIT_DONE: begin
                    if (w_edge) begin
                        r_v <= bus.SampledValue;
                    end else if (w_timeout) begin
                        r_v   <= 2'b00;
                        r_err <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_plane0 <= {r_plane0[6:0], r_v[0]};
                    r_plane1 <= {r_plane1[6:0], r_v[1]};
                end
                S_ADVANCE: begin
                    if (w_last_x) begin
                        r_x <= 7'd0;
                        r_y <= w_last_y ? 7'd0 : r_y + 7'd1;
                    end else begin
                        r_x <= r_x + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign SampleError     = r_err;
    assign bus.SampleStart = w_start;
    assign bus.PixelX      = r_x;
    assign bus.PixelY      = r_y;
    assign bus.FbWriteEn   = w_wen;
    assign bus.FbWriteAddr = w_waddr;
    assign bus.FbWriteData = w_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ag32gbd_frame_scanner.sv
`default_nettype none
// ============================================================================
// tb_ag32gbd_frame_scanner : randomized sampler model with a scoreboard of
// expected frame-buffer writes built from a tile-format reference.   Rev 1.0
// ============================================================================
module tb_ag32gbd_frame_scanner;

    // Reduced raster keeps whole frames short; 24x10 still covers X=8,Y=9.
    localparam int          W   = 24;
    localparam int          H   = 10;
    localparam int          SH  = 4;
    localparam logic [15:0] TMO = 16'd100;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic frame_start = 1'b0;
    logic frame_busy, frame_done, sample_error;

    ag32gbd_frame_scanner_if bus();

    ag32gbd_frame_scanner #(
        .WIDTH(W), .HEIGHT(H), .START_HOLD(SH), .TIMEOUT(TMO)
    ) u_dut (
        .sys_clock  (clk),
        .sys_resetn (rstn),
        .FrameStart (frame_start),
        .FrameBusy  (frame_busy),
        .FrameDone  (frame_done),
        .SampleError(sample_error),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    int   vectors = 0;
    int   miscompares = 0;
    wr_t  exp_q[$];
    logic [1:0] val [H][W];
    bit   sup_en = 1'b0;
    int   long_x = -1, long_y = -1;
    int   fix_lat = 0, fix_str = 0;
    int   done_cnt = 0, wr_cnt = 0, overlap = 0, seen_n = 0;
    logic [11:0] seen_lo = 12'd0, seen_hi = 12'd0;
    logic [7:0]  fb [4096];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] pix(input int x, input int y);
        return (sup_en && x == 0 && y == 0) ? 2'b00 : val[y][x];
    endfunction

    task automatic fill(input bit diag);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                val[y][x] = diag ? 2'((x + y) % 4) : 2'($urandom_range(3, 0));
    endtask

    // Reference: each 8-pixel run of a row becomes a lo/hi byte pair, leftmost pixel in bit 7.
    task automatic push_frame();
        int tile, a;
        logic [7:0] lo, hi;
        logic [1:0] v;
        for (int y = 0; y < H; y++) begin
            for (int g = 0; g < W / 8; g++) begin
                tile = (y / 8) * (W / 8) + g;
                a    = tile * 16 + (y % 8) * 2;
                for (int i = 0; i < 8; i++) begin
                    v         = pix(8 * g + i, y);
                    lo[7 - i] = v[0];
                    hi[7 - i] = v[1];
                end
                exp_q.push_back('{addr: 12'(a), data: lo});
                exp_q.push_back('{addr: 12'(a + 1), data: hi});
            end
        end
    endtask

    task automatic begin_frame();
        done_cnt = 0;
        seen_n   = 0;
        push_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("start_timing", {30'd0, frame_busy, bus.SampleStart}, 32'd3);
    endtask

    task automatic wait_frame(input int bound);
        int n;
        n = 0;
        while (!frame_done && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!frame_done) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_done_wait: no FrameDone after %0d cycles", n);
        end
        repeat (3) @(negedge clk);
        check("frame_done_count", done_cnt, 1);
        check("writes_pending", exp_q.size(), 0);
        check("busy_after_frame", frame_busy, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {27'd0, frame_busy, frame_done, sample_error, bus.SampleStart, bus.FbWriteEn}, 32'd0);
        check({tag, "_xy"}, {18'd0, bus.PixelX, bus.PixelY}, 32'd0);
        check({tag, "_bus"}, {12'd0, bus.FbWriteAddr, bus.FbWriteData}, 32'd0);
    endtask

    // Sampler model: latency counted from the SampleStart rise, then a stretched done level.
    initial begin : sampler
        bit busy, ph, prev;
        int cnt, sx, sy;
        busy = 0; ph = 0; prev = 0; cnt = 0; sx = 0; sy = 0;
        bus.SampleDone   = 1'b0;
        bus.SampledValue = 2'b00;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                busy           = 0;
                bus.SampleDone = 1'b0;
            end else if (busy) begin
                cnt--;
                if (cnt <= 0) begin
                    if (!ph) begin
                        if (sup_en && sx == 0 && sy == 0) begin
                            busy = 0;
                        end else begin
                            bus.SampleDone   = 1'b1;
                            bus.SampledValue = val[sy][sx];
                            ph  = 1;
                            cnt = (sx == long_x && sy == long_y) ? 50 :
                                  (fix_str > 0 ? fix_str : int'($urandom_range(5, 1)));
                        end
                    end else begin
                        bus.SampleDone   = 1'b0;
                        bus.SampledValue = 2'($urandom);
                        busy = 0;
                    end
                end
            end else if (bus.SampleStart && !prev) begin
                busy = 1;
                ph   = 0;
                sx   = int'(bus.PixelX);
                sy   = int'(bus.PixelY);
                cnt  = fix_lat > 0 ? fix_lat : int'($urandom_range(10, SH));
            end
            prev = rstn ? bus.SampleStart : 1'b0;
        end
    end

    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (bus.SampleStart && bus.SampleDone) overlap++;
                if (frame_done) done_cnt++;
                if (bus.FbWriteEn) begin
                    wr_cnt++;
                    fb[bus.FbWriteAddr] = bus.FbWriteData;
                    if (bus.PixelX == 7'd15 && bus.PixelY == 7'd9) begin
                        if (seen_n == 0) seen_lo = bus.FbWriteAddr;
                        else             seen_hi = bus.FbWriteAddr;
                        seen_n++;
                    end
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL write: unexpected addr=%0d data=0x%02h with none pending",
                                 bus.FbWriteAddr, bus.FbWriteData);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.FbWriteAddr !== e.addr || bus.FbWriteData !== e.data) begin
                            miscompares++;
                            $display("FAIL write: got addr=%0d data=0x%02h, want addr=%0d data=0x%02h",
                                     bus.FbWriteAddr, bus.FbWriteData, e.addr, e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin : main
        int k;
        logic [6:0] px, py;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Frame 1: diagonal pattern, fixed 20-cycle latency, 7-cycle stretch.
        fill(1'b1);
        fix_lat = 20;
        fix_str = 7;
        begin_frame();
        wait_frame(30000);
        check("error_clean", sample_error, 0);
        check("byte0", fb[0], 32'h55);
        check("byte1", fb[1], 32'h33);
        check("addr_x8y9_lo", seen_lo, ((9 / 8) * (W / 8) + 1) * 16 + (9 % 8) * 2);
        check("addr_x8y9_hi", seen_hi, ((9 / 8) * (W / 8) + 1) * 16 + (9 % 8) * 2 + 1);

        // Frame 2: random data/timing, one long done level, FrameStart mid-frame.
        fill(1'b0);
        fix_lat = 0;
        fix_str = 0;
        long_x  = 3;
        long_y  = 2;
        begin_frame();
        k = 0;
        while (!(bus.SampleStart && bus.PixelX == 7'd5 && bus.PixelY == 7'd1) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        px = bus.PixelX;
        py = bus.PixelY;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("midstart_xy", {18'd0, bus.PixelX, bus.PixelY}, {18'd0, 7'd5, 7'd1});
        check("midstart_xy_held", {18'd0, bus.PixelX, bus.PixelY}, {18'd0, px, py});
        check("midstart_busy", frame_busy, 1);
        wait_frame(30000);
        check("error_clean2", sample_error, 0);
        long_x = -1;
        long_y = -1;

        // Frame 3: pixel (0,0) never answered.
        fill(1'b0);
        sup_en = 1'b1;
        begin_frame();
        k = 0;
        while (!sample_error && k < int'(TMO) + 50) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (k < int'(TMO) || k > int'(TMO) + 2) begin
            miscompares++;
            $display("FAIL timeout_latency: got %0d cycles, want %0d..%0d", k, TMO, TMO + 2);
        end
        wait_frame(30000);
        check("error_sticky", sample_error, 1);
        sup_en = 1'b0;

        // Frame 4: new FrameStart clears the error; reset lands mid-frame.
        fill(1'b0);
        begin_frame();
        check("error_cleared", sample_error, 0);
        k = wr_cnt;
        while (wr_cnt < k + 20 && wr_cnt < k + 1000) @(negedge clk);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1 check_outputs_zero("async_reset");
        exp_q.delete();
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        k = wr_cnt;
        repeat (20) @(negedge clk);
        check("no_writes_after_reset", wr_cnt - k, 0);
        check("idle_after_reset", frame_busy, 0);

        // Frame 5: restarts at (0,0) with a clean scan.
        fill(1'b0);
        begin_frame();
        check("restart_xy", {18'd0, bus.PixelX, bus.PixelY}, 0);
        wait_frame(30000);
        check("error_clean5", sample_error, 0);

        check("start_done_overlap", overlap, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ag32gbd_frame_scanner.md
# ag32gbd_frame_scanner

Frame-level controller in front of the per-pixel sampler. It walks the 128x112 sensor raster, requests one sample per pixel, and packs the returned 2-bit values into Game Boy 2bpp tile format. It writes the packed bytes into the frame buffer BRAM consumed by the host/video path. It owns the sampler handshake, including the start pulse, the done-edge wait, the done-low wait and a per-pixel timeout.

## Interface
- WIDTH, 128: pixels per row; multiple of 8, at most 128.
- HEIGHT, 112: rows per frame; at most 128.
- START_HOLD, 4: cycles SampleStart is held high per request; must be at least 2.
- TIMEOUT, 16'd4095: cycles allowed from SampleStart rise to SampleDone rise.

Ports:
- sys_clock  in  1  100MHz system clock.
- sys_resetn  in  1  asynchronous, active-low reset.
- FrameStart  in  1  single-cycle request to capture one frame.
- FrameBusy  out  1  high from accepted FrameStart until FrameDone.
- FrameDone  out  1  one-cycle pulse after the last byte is written.
- SampleError  out  1  sticky; set on any pixel timeout, cleared when a FrameStart is accepted.
- SampleStart  out  1  request to the sampler.
- PixelX  out  7  current column; stable while a request is outstanding.
- PixelY  out  7  current row; stable while a request is outstanding.
- SampleDone  in  1  sampler done level, stretched over several cycles.
- SampledValue  in  2  pixel value; valid while SampleDone is high.
- FbWriteEn  out  1  one-cycle write strobe.
- FbWriteAddr  out  12  byte address in the frame buffer.
- FbWriteData  out  8  byte to write.

## Operation
- Reset: all outputs are 0. State is IDLE. Pixel counters, plane shift registers and the timeout counter are 0. Reset asserted mid-frame abandons the frame immediately and no further writes occur.
- IDLE:
  - On FrameStart: X=Y=0, clear SampleError, FrameBusy=1, go to START.
  - FrameStart while not in IDLE is ignored.
- START: SampleStart=1 for START_HOLD cycles, then SampleStart=0 and go to WAIT_DONE. The timeout counter runs from the first START cycle.
- WAIT_DONE:
  - Act on the rising edge of SampleDone, detected against a 1-cycle registered copy.
  - On the edge, go to CAPTURE with v=SampledValue.
  - If the counter reaches TIMEOUT first: v=2'b00, SampleError=1, go to CAPTURE.
- CAPTURE:
  - Shift Plane0 <= {Plane0[6:0], v[0]} and Plane1 <= {Plane1[6:0], v[1]}, so the leftmost pixel of each 8-pixel group lands in bit 7.
  - If X[2:0]==7, go to WRITE_LO; else go to WAIT_LOW.
- WRITE_LO: FbWriteEn=1, FbWriteAddr=base, FbWriteData=Plane0.
- WRITE_HI: FbWriteEn=1, FbWriteAddr=base+1, FbWriteData=Plane1. Then go to WAIT_LOW.
- Write address:
  - base = tile*16 + Y[2:0]*2.
  - tile = Y[6:3]*(WIDTH/8) + X[6:3].
  - For 128x112: 224 tiles, bytes 0..3583. The 12-bit address must not overflow.
- WAIT_LOW: wait until SampleDone==0 (this guarantees the sampler is idle), then go to ADVANCE. A timed-out pixel also waits here. A SampleDone stuck high stalls the block with no escape except reset.
- ADVANCE:
  - X wraps WIDTH-1 to 0 and increments Y.
  - If X==WIDTH-1 and Y==HEIGHT-1, go to FINISH; else go to START.
- FINISH: FrameDone=1 for one cycle, FrameBusy=0, go to IDLE. The plane registers hold stale data and are not cleared.
- A SampleDone rising edge outside WAIT_DONE is ignored.

## Timing
- FrameStart at cycle 0: FrameBusy=1 and SampleStart=1 from cycle 1.
- Per pixel: START_HOLD + sampler latency + 1 (CAPTURE) + WAIT_LOW duration + 1 (ADVANCE). Every 8th pixel adds 2 write cycles.
- The two writes of a row-group are on consecutive cycles, lo then hi.
- PixelX/PixelY change only in ADVANCE.
- FrameDone occurs 1 cycle after the WAIT_LOW/ADVANCE of the last pixel. Exactly WIDTH*HEIGHT/4 writes occur per frame (3584 for the defaults).

## Test plan
- Sampler model returns v=(X+Y)%4 with 20-cycle latency and a 7-cycle done stretch; run one frame -> 3584 writes. Byte 0 = 8'b0101_0101 (Plane0 of row 0, tile 0) and byte 1 = 8'b0011_0011. FrameDone pulses once and SampleError=0.
- Check addressing at X=8, Y=9 (tile 17, row 1) -> the lo write for that group lands at 17*16+2 = 274 and hi at 275.
- Model never answers pixel (0,0) -> after TIMEOUT cycles SampleError=1, pixel 0 is packed as 00, and the scan continues. A new FrameStart clears SampleError.
- SampleDone held high for 50 cycles -> no next SampleStart until it falls, and no double capture.
- FrameStart pulsed mid-frame -> ignored, X/Y unaffected.
- sys_resetn asserted mid-frame -> all outputs 0 at once. After release the block is IDLE, and the next FrameStart restarts at (0,0).
